// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch condition codes, flag bit positions,
// register constants and the PC redirect controller state encoding.
package cpu_pkg;

   typedef enum logic [2:0] {
      COND_NE  = 3'b000,
      COND_EQ  = 3'b001,
      COND_GT  = 3'b010,
      COND_LT  = 3'b011,
      COND_GE  = 3'b100,
      COND_LE  = 3'b101,
      COND_OV  = 3'b110,
      COND_UNC = 3'b111
   } branch_cond_t;

   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

   localparam logic [3:0] SP_REG = 4'b1111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_FLAGS,
      ST_WAIT_SP,
      ST_EVAL,
      ST_REDIRECT
   } pc_redirect_state_t;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Request/response bundle between the EX stage and the PC redirect
// controller. The master side raises requests and supplies operands,
// the slave side is the controller.
interface pc_redirect_ctrl_if;

   logic        branch;
   logic        call;
   logic        ret;
   logic [2:0]  branch_cond;
   logic [11:0] call_target;
   logic [15:0] sign_ext;
   logic [15:0] PC_in;
   logic        flags_busy;
   logic        alu_done;
   logic [2:0]  flags;
   logic        ret_wb;
   logic [15:0] PC_stack_pointer;

   logic        stall;
   logic        flush;
   logic        PC_src;
   logic [15:0] PC_update;
   logic        update_done;

   modport master (
      output branch, call, ret, branch_cond, call_target, sign_ext, PC_in,
             flags_busy, alu_done, flags, ret_wb, PC_stack_pointer,
      input  stall, flush, PC_src, PC_update, update_done
   );

   modport slave (
      input  branch, call, ret, branch_cond, call_target, sign_ext, PC_in,
             flags_busy, alu_done, flags, ret_wb, PC_stack_pointer,
      output stall, flush, PC_src, PC_update, update_done
   );

endinterface

// File: rtl/pc_redirect_ctrl_cond_eval.sv
// Combinational branch condition evaluator: maps a condition code and the
// {Z,V,N} flag vector to a taken decision. Kept standalone so early-branch
// logic can reuse it.
module branch_cond_eval
   import cpu_pkg::*;
(
   input  branch_cond_t cond,
   input  logic [2:0]   flags,
   output logic         taken
);

   logic z_flag;
   logic v_flag;
   logic n_flag;

   assign z_flag = flags[FLAG_Z];
   assign v_flag = flags[FLAG_V];
   assign n_flag = flags[FLAG_N];

   // Decode the condition code against the current flags
   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_NE:  taken = ~z_flag;
         COND_EQ:  taken = z_flag;
         COND_GT:  taken = ~z_flag & ~n_flag;
         COND_LT:  taken = n_flag;
         COND_GE:  taken = z_flag | ~n_flag;
         COND_LE:  taken = z_flag | n_flag;
         COND_OV:  taken = v_flag;
         COND_UNC: taken = 1'b1;
         default:  taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect sequencer for the EX stage. Accepts one branch/call/ret at a
// time, waits for flags or the return address as needed, then issues a
// single redirect pulse followed by a FLUSH_CYCLES-long flush window.
module pc_redirect_ctrl
   import cpu_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   pc_redirect_ctrl_if.slave  bus
);

   localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

   pc_redirect_state_t state_q, state_d;
   logic [2:0]         flush_cnt_q, flush_cnt_d;
   logic [15:0]        target_q, target_d;
   branch_cond_t       cond_q, cond_d;
   logic [15:0]        pc_update_q, pc_update_d;
   logic               taken;

   branch_cond_eval u_cond_eval (
      .cond  (cond_q),
      .flags (bus.flags),
      .taken (taken)
   );

   // State and datapath registers, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         flush_cnt_q <= 3'd0;
         target_q    <= 16'd0;
         cond_q      <= COND_NE;
         pc_update_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         target_q    <= target_d;
         cond_q      <= cond_d;
         pc_update_q <= pc_update_d;
      end
   end

   // Next-state logic; PC_update is loaded only on entry to REDIRECT so it
   // holds the last redirect target at all other times
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      target_d    = target_q;
      cond_d      = cond_q;
      pc_update_d = pc_update_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.ret) begin
               state_d = ST_WAIT_SP;
            end else if (bus.call) begin
               target_d    = {bus.PC_in[15:12], bus.call_target};
               pc_update_d = {bus.PC_in[15:12], bus.call_target};
               flush_cnt_d = 3'd0;
               state_d     = ST_REDIRECT;
            end else if (bus.branch) begin
               target_d = bus.PC_in + bus.sign_ext;
               cond_d   = branch_cond_t'(bus.branch_cond);
               state_d  = bus.flags_busy ? ST_WAIT_FLAGS : ST_EVAL;
            end
         end
         ST_WAIT_FLAGS: begin
            if (bus.alu_done) begin
               state_d = ST_EVAL;
            end
         end
         ST_WAIT_SP: begin
            if (bus.ret_wb) begin
               target_d    = bus.PC_stack_pointer;
               pc_update_d = bus.PC_stack_pointer;
               flush_cnt_d = 3'd0;
               state_d     = ST_REDIRECT;
            end
         end
         ST_EVAL: begin
            if (taken) begin
               pc_update_d = target_q;
               flush_cnt_d = 3'd0;
               state_d     = ST_REDIRECT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REDIRECT: begin
            if (flush_cnt_q == FLUSH_LAST) begin
               flush_cnt_d = 3'd0;
               state_d     = ST_IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q + 3'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Moore output decode plus the combinational stall that holds the
   // requester during its own acceptance cycle
   always_comb begin
      bus.stall       = (state_q != ST_IDLE) | bus.branch | bus.call | bus.ret;
      bus.flush       = 1'b0;
      bus.PC_src      = 1'b0;
      bus.update_done = 1'b0;
      bus.PC_update   = pc_update_q;
      case (state_q)
         ST_EVAL: begin
            bus.update_done = ~taken;
         end
         ST_REDIRECT: begin
            bus.flush = 1'b1;
            if (flush_cnt_q == 3'd0) begin
               bus.PC_src      = 1'b1;
               bus.update_done = 1'b1;
            end
         end
         default: begin
            bus.flush = 1'b0;
         end
      endcase
   end

endmodule
